// File: rtl/ahci_hba_reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ahci_pkg
// Shared definitions for the AHCI HBA register-port arbiter:
//   - requester index constants (control FSM, FIS receive, FIS transmit)
//   - fixed read latency of the HBA register memory
//   - register-port access record driven onto the memory port
// -----------------------------------------------------------------------------
package ahci_pkg;

    localparam int REQ_CTL = 0;
    localparam int REQ_RX  = 1;
    localparam int REQ_TX  = 2;

    // Cycles from hba_re[0] to valid hba_dout.
    localparam int HBA_READ_LATENCY = 2;

    // Default register memory address width.
    localparam int HBA_ADDRESS_BITS = 10;

    // One access as registered onto the HBA register port.
    typedef struct packed {
        logic [HBA_ADDRESS_BITS-1:0] addr;
        logic                        we;
        logic [31:0]                 wdata;
    } hba_access_t;

endpackage

// File: rtl/ahci_hba_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// ahci_hba_reg_arbiter_if
// Bundles the requester-side handshake and the HBA register memory port.
//   slave  : seen by the arbiter (takes requests and hba_dout, drives grants,
//            read returns and the memory port)
//   master : seen by the requesters / memory model (the mirror image)
// Signals:
//   req/req_we/req_lock   per-requester request, direction and lock
//   req_addr/req_wdata    packed per-requester address and write data
//   gnt/rvalid/rdata      one-hot grant, one-hot read valid, shared read data
//   hba_addr/hba_we/hba_re/hba_din/hba_dout   register memory port
// -----------------------------------------------------------------------------
interface ahci_hba_reg_arbiter_if #(
    parameter int ADDRESS_BITS = ahci_pkg::HBA_ADDRESS_BITS,
    parameter int NREQ         = 3
);
    logic [NREQ-1:0]              req;
    logic [NREQ-1:0]              req_we;
    logic [NREQ-1:0]              req_lock;
    logic [NREQ*ADDRESS_BITS-1:0] req_addr;
    logic [NREQ*32-1:0]           req_wdata;
    logic [NREQ-1:0]              gnt;
    logic [NREQ-1:0]              rvalid;
    logic [31:0]                  rdata;

    logic [ADDRESS_BITS-1:0]      hba_addr;
    logic                         hba_we;
    logic [1:0]                   hba_re;
    logic [31:0]                  hba_din;
    logic [31:0]                  hba_dout;

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata, hba_dout,
        output gnt, rvalid, rdata, hba_addr, hba_we, hba_re, hba_din
    );

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata, hba_dout,
        input  gnt, rvalid, rdata, hba_addr, hba_we, hba_re, hba_din
    );

endinterface

// File: rtl/ahci_hba_reg_arbiter_prio.sv
// -----------------------------------------------------------------------------
// ahci_arb_prio
// Combinational NREQ-way one-hot selector. The search starts at the index
// after ptr_i and wraps modulo NREQ; the first requester found wins.
// Pinning ptr_i to NREQ-1 turns it into a lowest-index-wins fixed priority.
// Ports:
//   req_i  NREQ   request vector
//   ptr_i  IDX_W  last granted index (search starts at ptr_i+1)
//   gnt_o  NREQ   one-hot grant, zero when nothing is requested
// -----------------------------------------------------------------------------
module ahci_arb_prio #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahci_hba_reg_arbiter.sv
// -----------------------------------------------------------------------------
// ahci_hba_reg_arbiter
// Shares the single HBA register memory port between NREQ requesters
// (0 = control FSM, 1 = FIS receive, 2 = FIS transmit). One access is granted
// per cycle, registered onto the port the next cycle, and read data is routed
// back to its requester READ_LATENCY+1 cycles after acceptance. A grant with
// req_lock set keeps the requester as owner until it is granted without lock
// or stops requesting.
// Build option: AHCI_REG_ARB_RR_EN selects round-robin priority; without it
// the lowest requester index wins.
// Ports:
//   mclk     clock for the port and all requesters
//   hba_rst  asynchronous active-high reset
//   bus      ahci_hba_reg_arbiter_if.slave (requests, grants, read return,
//            HBA register port)
// -----------------------------------------------------------------------------
module ahci_hba_reg_arbiter
    import ahci_pkg::*;
#(
    parameter int ADDRESS_BITS = HBA_ADDRESS_BITS,
    parameter int NREQ         = 3,
    parameter int READ_LATENCY = HBA_READ_LATENCY
) (
    input  logic                         mclk,
    input  logic                         hba_rst,
    ahci_hba_reg_arbiter_if.slave        bus
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Stage 0 lines up with hba_re[0], stage READ_LATENCY with valid hba_dout.
    localparam int STAGES = READ_LATENCY + 1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

    logic              owner_vld_q, owner_vld_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  arb_ptr;
    logic [NREQ-1:0]   arb_gnt;
    logic [NREQ-1:0]   gnt;
    logic              lock_hit;
    logic              accept;
    logic [IDX_W-1:0]  gnt_idx;
    logic [ADDRESS_BITS-1:0] addr_sel;
    logic [31:0]       wdata_sel;
    hba_access_t       port_q, port_d;
    rd_tag_t           tag_d;
    rd_tag_t           tag_q [STAGES];

    // ------------------------------------------------------------------ grant
    // The owner keeps the port only while it is still requesting; otherwise
    // everybody competes in the same cycle, so a lock release costs no bubble.
    assign lock_hit = owner_vld_q & bus.req[owner_q];

    ahci_arb_prio #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req_i (bus.req),
        .ptr_i (arb_ptr),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        gnt = arb_gnt;
        if (lock_hit) begin
            gnt          = '0;
            gnt[owner_q] = 1'b1;
        end
    end

    assign accept  = |gnt;
    assign bus.gnt = gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = IDX_W'(i);
        end
    end

    assign addr_sel  = bus.req_addr[gnt_idx*ADDRESS_BITS +: ADDRESS_BITS];
    assign wdata_sel = bus.req_wdata[gnt_idx*32 +: 32];

`ifdef AHCI_REG_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Grants won through the lock do not move the pointer, so a locked
    // sequence counts as a single turn.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && !lock_hit) ptr_d = gnt_idx;
    end

    always_ff @(posedge mclk or posedge hba_rst) begin
        if (hba_rst) ptr_q <= IDX_W'(NREQ - 1);
        else         ptr_q <= ptr_d;
    end

    assign arb_ptr = ptr_q;
`else
    // Search always starts at index 0: lowest index wins.
    assign arb_ptr = IDX_W'(NREQ - 1);
`endif

    // ----------------------------------------------------------- next state
    always_comb begin
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        if (accept) begin
            owner_vld_d = bus.req_lock[gnt_idx];
            owner_d     = gnt_idx;
        end else begin
            // Nobody, including the owner, is requesting: the lock lapses.
            owner_vld_d = 1'b0;
        end
    end

    always_comb begin
        port_d    = port_q;
        port_d.we = 1'b0;
        if (accept) begin
            port_d.addr  = addr_sel;
            port_d.we    = bus.req_we[gnt_idx];
            port_d.wdata = wdata_sel;
        end
    end

    always_comb begin
        tag_d.valid = accept & ~bus.req_we[gnt_idx];
        tag_d.idx   = gnt_idx;
    end

    // -------------------------------------------------------------- registers
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge mclk or posedge hba_rst) begin
        if (hba_rst) begin
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
            port_q      <= '0;
            // NOTE: the tag array is a short pipeline, not storage, so it is
            // reset; that is what drops in-flight reads on reset.
            for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
            port_q      <= port_d;
            tag_q[0]    <= tag_d;
            for (int s = 1; s < STAGES; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // ----------------------------------------------------------------- outputs
    assign bus.hba_addr = port_q.addr;
    assign bus.hba_we   = port_q.we;
    assign bus.hba_din  = port_q.wdata;
    assign bus.hba_re   = {tag_q[READ_LATENCY-1].valid, tag_q[0].valid};
    assign bus.rdata    = bus.hba_dout;

    always_comb begin
        bus.rvalid = '0;
        if (tag_q[READ_LATENCY].valid) bus.rvalid[tag_q[READ_LATENCY].idx] = 1'b1;
    end

endmodule

// File: tb/tb_ahci_hba_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahci_hba_reg_arbiter
// Directed scenarios followed by randomized traffic. A register memory model
// with a two-cycle read path drives hba_dout; a transaction-level reference
// (owner, last-grant pointer, shadow memory, per-cycle expectation tables)
// predicts every grant and port/read-return value.
// Honours AHCI_REG_ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_ahci_hba_reg_arbiter;
    import ahci_pkg::*;

    localparam int AB   = 10;
    localparam int NREQ = 3;
    localparam int MAXC = 2048;
    localparam int MEMW = 1 << AB;

    logic mclk    = 1'b0;
    logic hba_rst = 1'b1;

    always #5 mclk = ~mclk;

    ahci_hba_reg_arbiter_if #(.ADDRESS_BITS(AB), .NREQ(NREQ)) bus ();

    ahci_hba_reg_arbiter #(
        .ADDRESS_BITS (AB),
        .NREQ         (NREQ),
        .READ_LATENCY (HBA_READ_LATENCY)
    ) dut (
        .mclk    (mclk),
        .hba_rst (hba_rst),
        .bus     (bus)
    );

    // Seed pattern so unwritten locations hold distinctive contents.
    function automatic bit [31:0] pat(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // ---------------------------------------------- register memory model
    bit [31:0] ram [MEMW];
    bit [31:0] ram_rd_q;
    bit [31:0] ram_dout_q;

    always @(posedge mclk) begin
        if (bus.hba_we)    ram[bus.hba_addr] <= bus.hba_din ^ pat(int'(bus.hba_addr));
        if (bus.hba_re[0]) ram_rd_q          <= ram[bus.hba_addr] ^ pat(int'(bus.hba_addr));
        if (bus.hba_re[1]) ram_dout_q        <= ram_rd_q;
    end

    assign bus.hba_dout = ram_dout_q;

    // -------------------------------------------------- reference model
    bit [31:0]      ref_mem   [MEMW];
    bit             exp_we    [MAXC];
    bit             exp_re0   [MAXC];
    bit             exp_re1   [MAXC];
    bit [NREQ-1:0]  exp_rv    [MAXC];
    bit [AB-1:0]    exp_addr  [MAXC];
    bit [31:0]      exp_din   [MAXC];
    bit [31:0]      exp_rdata [MAXC];
    int             owner;
    int             cyc;
`ifdef AHCI_REG_ARB_RR_EN
    int             last;
`endif

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = -1;
`ifdef AHCI_REG_ARB_RR_EN
        last  = NREQ - 1;
`endif
        for (int c = cyc; c < MAXC; c++) begin
            exp_we[c]    = 1'b0;
            exp_re0[c]   = 1'b0;
            exp_re1[c]   = 1'b0;
            exp_rv[c]    = '0;
            exp_addr[c]  = '0;
            exp_din[c]   = '0;
            exp_rdata[c] = '0;
        end
    endtask

    // Winner for the current request vector, -1 when nobody is requesting.
    function automatic int pick();
        int i;
        if (owner >= 0 && bus.req[owner]) return owner;
`ifdef AHCI_REG_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (bus.req[i]) return i;
        end
`else
        for (i = 0; i < NREQ; i++) begin
            if (bus.req[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic check_outputs();
        check("hba_we", 32'(bus.hba_we), 32'(exp_we[cyc]));
        check("hba_re", 32'(bus.hba_re), {30'd0, exp_re1[cyc], exp_re0[cyc]});
        check("rvalid", 32'(bus.rvalid), 32'(exp_rv[cyc]));
        if (exp_we[cyc] || exp_re0[cyc]) check("hba_addr", 32'(bus.hba_addr), 32'(exp_addr[cyc]));
        if (exp_we[cyc])                 check("hba_din", bus.hba_din, exp_din[cyc]);
        if (exp_rv[cyc] != '0)           check("rdata", bus.rdata, exp_rdata[cyc]);
    endtask

    // One clock: check the grant, advance the model, then check the
    // registered outputs half a cycle after the edge.
    task automatic tick();
        int g;
        int a;
        bit [31:0] d;
`ifdef AHCI_REG_ARB_RR_EN
        bit via_lock;
`endif
        #1;
        g = pick();
        check("gnt", 32'(bus.gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
`ifdef AHCI_REG_ARB_RR_EN
            via_lock = (owner >= 0) && bus.req[owner];
`endif
            a = int'(bus.req_addr[g*AB +: AB]);
            d = bus.req_wdata[g*32 +: 32];
            exp_addr[cyc+1] = AB'(a);
            if (bus.req_we[g]) begin
                ref_mem[a]     = d;
                exp_we[cyc+1]  = 1'b1;
                exp_din[cyc+1] = d;
            end else begin
                exp_re0[cyc+1]   = 1'b1;
                exp_re1[cyc+2]   = 1'b1;
                exp_rv[cyc+3]    = NREQ'(1) << g;
                exp_rdata[cyc+3] = ref_mem[a];
            end
            owner = bus.req_lock[g] ? g : -1;
`ifdef AHCI_REG_ARB_RR_EN
            if (!via_lock) last = g;
`endif
        end else begin
            owner = -1;
        end
        @(posedge mclk);
        cyc++;
        @(negedge mclk);
        check_outputs();
    endtask

    task automatic clear_reqs();
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drive(input int i, input bit we, input bit lk, input int addr, input bit [31:0] d);
        bus.req[i]                 = 1'b1;
        bus.req_we[i]              = we;
        bus.req_lock[i]            = lk;
        bus.req_addr[i*AB +: AB]   = AB'(addr);
        bus.req_wdata[i*32 +: 32]  = d;
    endtask

    task automatic check_port_idle(input string tag);
        check({tag, "_addr"},   32'(bus.hba_addr), 32'd0);
        check({tag, "_we"},     32'(bus.hba_we),   32'd0);
        check({tag, "_re"},     32'(bus.hba_re),   32'd0);
        check({tag, "_din"},    bus.hba_din,       32'd0);
        check({tag, "_rvalid"}, 32'(bus.rvalid),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [2:0] exp_rot;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        for (int a = 0; a < MEMW; a++) ref_mem[a] = pat(a);
        clear_reqs();
        hba_rst = 1'b1;
        model_reset();

        // Reset state.
        repeat (3) @(negedge mclk);
        check_port_idle("reset");
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        hba_rst = 1'b0;

        // All three requesting continuously from a fresh reset.
        for (int k = 0; k < 6; k++) begin
            clear_reqs();
            for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 1'b0, k, 32'd0);
`ifdef AHCI_REG_ARB_RR_EN
            exp_rot = 3'b001 << (k % 3);
`else
            exp_rot = 3'b001;
`endif
            #1;
            check("rotate", 32'(bus.gnt), 32'(exp_rot));
            tick();
        end
        clear_reqs();
        repeat (3) tick();

        // Single read by the transmit requester.
        drive(REQ_TX, 1'b0, 1'b0, 'h012, 32'd0);
        #1;
        check("single_gnt", 32'(bus.gnt), 32'b100);
        tick();
        check("single_re_t1", 32'(bus.hba_re), 32'b01);
        check("single_addr_t1", 32'(bus.hba_addr), 32'h012);
        clear_reqs();
        tick();
        check("single_re_t2", 32'(bus.hba_re), 32'b10);
        tick();
        check("single_rvalid", 32'(bus.rvalid), 32'b100);
        check("single_rdata", bus.rdata, pat('h012));

        // Write then read of the same address on consecutive cycles.
        drive(REQ_CTL, 1'b1, 1'b0, 'h100, 32'hA5A5_1234);
        tick();
        clear_reqs();
        drive(REQ_RX, 1'b0, 1'b0, 'h100, 32'd0);
        tick();
        clear_reqs();
        tick();
        tick();
        check("raw_rvalid", 32'(bus.rvalid), 32'b010);
        check("raw_rdata", bus.rdata, 32'hA5A5_1234);

        // Locked read-modify-write by the receive requester.
        drive(REQ_RX, 1'b0, 1'b1, 'h040, 32'd0);
        tick();
        drive(REQ_CTL, 1'b0, 1'b0, 'h200, 32'd0);
        drive(REQ_RX, 1'b1, 1'b0, 'h040, 32'hDEAD_BEEF);
        #1;
        check("rmw_owner_gnt", 32'(bus.gnt), 32'b010);
        tick();
        bus.req[REQ_RX] = 1'b0;
        #1;
        check("rmw_ctl_after", 32'(bus.gnt), 32'b001);
        tick();
        clear_reqs();
        drive(REQ_TX, 1'b0, 1'b0, 'h040, 32'd0);
        tick();
        clear_reqs();
        repeat (3) tick();
        check("rmw_readback", bus.rdata, 32'hDEAD_BEEF);

        // Lock owner drops its request: someone else wins the same cycle.
        drive(REQ_RX, 1'b0, 1'b1, 'h010, 32'd0);
        tick();
        clear_reqs();
        drive(REQ_TX, 1'b0, 1'b0, 'h020, 32'd0);
        #1;
        check("lock_drop_gnt", 32'(bus.gnt), 32'b100);
        tick();
        clear_reqs();
        repeat (3) tick();

        // Reset pulse while a read is two cycles in flight.
        drive(REQ_TX, 1'b0, 1'b0, 'h030, 32'd0);
        tick();
        clear_reqs();
        tick();
        hba_rst = 1'b1;
        #1;
        check_port_idle("rst_mid");
        model_reset();
        @(posedge mclk);
        cyc++;
        @(negedge mclk);
        check_port_idle("rst_hold");
        hba_rst = 1'b0;
        repeat (5) tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            clear_reqs();
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    drive(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MEMW - 1))
                                                      : int'($urandom_range(0, 7)),
                          $urandom);
                end
            end
            tick();
        end
        clear_reqs();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahci_hba_reg_arbiter.md
# ahci_hba_reg_arbiter

Single-port access arbiter for the HBA register memory port (`hba_addr`/`hba_we`/`hba_re`/`hba_din`/`hba_dout`) of the AHCI register block. It shares that one port between up to NREQ requesters: FIS receive register writes, FIS transmit register reads, and the AHCI control FSM. It registers the winning access onto the port and returns read data to the correct requester after the fixed read latency. It also supports locked multi-access sequences such as read-modify-write.

## Interface
Parameters:
- ADDRESS_BITS, 10: register memory address width.
- NREQ, 3: number of requesters. Index 0 = control FSM, 1 = FIS receive, 2 = FIS transmit.
- READ_LATENCY, 2: cycles from `hba_re[0]` to valid `hba_dout`. Fixed at 2.

Ports:
- mclk  in  1  clock. The HBA register port and all requesters run on it.
- hba_rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  access request per requester. Held until granted.
- req_we  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  keep ownership after this grant.
- req_addr  in  NREQ*ADDRESS_BITS  packed addresses. Requester i occupies bits [i*ADDRESS_BITS +: ADDRESS_BITS].
- req_wdata  in  NREQ*32  packed write data.
- gnt  out  NREQ  one-hot grant, combinational. Access is accepted when `req[i] & gnt[i]`.
- rvalid  out  NREQ  one-hot read-data valid.
- rdata  out  32  read data, shared by all requesters.
- hba_addr  out  ADDRESS_BITS  register port address.
- hba_we  out  1  register port write enable.
- hba_re  out  2  [0] read enable, [1] output register enable.
- hba_din  out  32  register port write data.
- hba_dout  in  32  register port read data.

## Operation
- At most one grant per cycle, giving a throughput of one access per cycle. `gnt` is only asserted for a requester whose `req` is high.
- Selection order:
  - If a lock owner exists and its `req` is high, the owner wins.
  - If the owner's `req` is low, the lock is released and normal arbitration applies in the same cycle.
  - Otherwise, priority as set under Configuration.
- Lock: a grant with `req_lock[i]=1` makes requester i the owner. A grant with `req_lock[i]=0` clears ownership.
- Accepted access at cycle T:
  - At T+1, `hba_addr`, `hba_din` and `hba_we` (write) or `hba_re[0]` (read) are driven from registers.
  - For a read, `hba_re[1]` is driven at T+2.
  - For a read, `hba_dout` is captured as valid at T+3: `rvalid[i]=1` and `rdata=hba_dout` in that cycle.
- Read-return routing uses a 3-stage tag pipeline (valid + requester index) aligned with the port stages. It is independent of new grants, so reads from different requesters may be in flight back-to-back.
- A write at T followed by a read of the same address at T+1 returns the new data. The port writes at T+1 and reads at T+2.
- `rdata` is undefined when no `rvalid` bit is set. It is driven as a combinational pass-through of `hba_dout`.
- Widths: addresses and data pass through unmodified. There is no arithmetic except the priority pointer, which wraps modulo NREQ.

## Timing
- Reset values:
  - `hba_addr`=0, `hba_we`=0, `hba_re`=0, `hba_din`=0.
  - Tag pipeline cleared, so `rvalid`=0.
  - Lock owner = none.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
- `gnt` is combinational from `req` and state only. It is never a function of the `hba_*` outputs.
- Read latency is exactly 3 cycles from acceptance to `rvalid`. Write latency is 1 cycle to `hba_we`.
- No idle cycles between consecutive grants. `hba_we` and `hba_re[0]` are never high in the same cycle.
- Reset asserted mid-read: all in-flight tags are dropped. No `rvalid` is issued after reset release for pre-reset reads.
- Requester drops `req` without a grant: no effect, and the request is not queued.
- Simultaneous lock-owner release and new requests: arbitration among all requesters in the same cycle. No bubble.

## Configuration
- `AHCI_REG_ARB_RR_EN` defined: round-robin priority.
  - Search starts at the index after the last granted requester.
  - The pointer updates only on unlocked grants and on the first grant of a locked sequence.
- Not defined: fixed priority, lowest index wins. The pointer is not implemented.

## Structure
- Shared package (ahci_pkg):
  - Requester index constants (REQ_CTL=0, REQ_RX=1, REQ_TX=2).
  - HBA_READ_LATENCY=2.
  - Register-port access struct (addr, we, wdata) typedef.
- One sub-module, `ahci_arb_prio`: a combinational NREQ-way priority/round-robin one-hot selector taking `req` and the pointer. Lock override and pipelines stay in the top.

## Test plan
- Single read: `req[2]=1`, `req_we=0`, `addr=0x012`. Expect:
  - `gnt[2]` same cycle.
  - `hba_re=01`, `hba_addr=0x012` at T+1.
  - `hba_re=10` at T+2.
  - `rvalid=100`, `rdata=hba_dout` at T+3.
- All three requesting continuously (RR_EN): grants rotate 0,1,2,0,… with no idle cycle. Without RR_EN, requester 0 is granted every cycle.
- Locked RMW:
  - Requester 1 reads 0x040 with lock=1, then writes 0xDEADBEEF with lock=0.
  - Requester 0 requesting throughout is not granted until after the write.
  - `hba_we` is at T+4 if the write is issued after `rvalid`.
- Write-then-read to 0x100 on consecutive cycles: the read returns the written value. `hba_we` and `hba_re[0]` are never simultaneous.
- `hba_rst` pulse at T+2 of a pending read: no `rvalid` afterward, and all `hba_*` outputs read 0 during reset.
- Lock owner drops `req` while holding the lock: another requester is granted in that same cycle.
